// File: rtl/serial_tx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | serial_tx_pkg : state encodings and line levels for the serial link |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/serial_tx_bit_timer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | bit_timer : counts clocks within one serial bit, pulses tick    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | serial_tx : UART-style parallel-to-serial frame transmitter     |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_t         r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic              r_parity, w_parity_nxt;
    logic              r_tx_out, w_tx_out_nxt;
    logic              r_tx_ready;
    logic              r_busy;
    logic              w_tick;
    logic              w_clr;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .tick(w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_parity   <= 1'b0;
            r_tx_out   <= LINE_IDLE;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_parity   <= w_parity_nxt;
            r_tx_out   <= w_tx_out_nxt;
            r_tx_ready <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_parity_nxt  = r_parity;
        case (r_state)
            ST_IDLE: begin
                if (tx_valid && r_tx_ready) begin
                    w_shift_nxt   = tx_data;
                    w_parity_nxt  = ^tx_data;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_tick) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Timer restarts on every state entry and is held at zero while idle.
        w_clr = (r_state == ST_IDLE) || (w_state_nxt != r_state);

        // Line level is decoded from next-state so tx_out stays a flop output.
        case (w_state_nxt)
            ST_START:  w_tx_out_nxt = START_BIT;
            ST_DATA:   w_tx_out_nxt = w_shift_nxt[0];
            ST_PARITY: w_tx_out_nxt = w_parity_nxt;
            default:   w_tx_out_nxt = LINE_IDLE;
        endcase
    end

    assign tx_out   = r_tx_out;
    assign tx_ready = r_tx_ready;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_serial_tx : directed scoreboard bench, parity off and on     |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_serial_tx;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid [2];
    logic [7:0] tx_data  [2];
    logic       tx_ready [2];
    logic       tx_out   [2];
    logic       busy     [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q [$];

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
        .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .busy(busy[0])
    );

    serial_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
        .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        chk({tag, ".tx_out"},   tx_out[sel],   1'b1);
        chk({tag, ".tx_ready"}, tx_ready[sel], 1'b1);
        chk({tag, ".busy"},     busy[sel],     1'b0);
    endtask

    // Expected line level for every clock of one frame.
    task automatic push_frame(input int sel, input logic [7:0] word);
        bit lv [$];
        lv.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) lv.push_back(word[i]);
        if (sel == 1) lv.push_back(^word);
        lv.push_back(1'b1);
        foreach (lv[b])
            for (int c = 0; c < CPB; c++) exp_q.push_back(lv[b]);
    endtask

    // Called at the negedge following the accepting edge; ends in first idle cycle.
    task automatic drain(input int sel, input string tag, input bit disturb, input int abort_at);
        int idx = 0;
        while (exp_q.size() > 0) begin
            chk($sformatf("%s.bit%0d", tag, idx), tx_out[sel], exp_q.pop_front());
            chk($sformatf("%s.busy%0d", tag, idx), busy[sel], 1'b1);
            chk($sformatf("%s.rdy%0d", tag, idx), tx_ready[sel], 1'b0);
            if (disturb) begin
                if (idx == 14) begin tx_data[sel] = 8'h3C; tx_valid[sel] = 1'b1; end
                if (idx == 20) tx_valid[sel] = 1'b0;
                if (idx == 24) tx_valid[sel] = 1'b1;
                if (idx == 38) tx_valid[sel] = 1'b0;
            end
            if (idx == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk({tag, ".abort_out"},  tx_out[sel],   1'b1);
                chk({tag, ".abort_busy"}, busy[sel],     1'b0);
                chk({tag, ".abort_rdy"},  tx_ready[sel], 1'b1);
                exp_q.delete();
            end
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] word, input bit hold, input string tag);
        tx_valid[sel] = 1'b1;
        tx_data[sel]  = word;
        push_frame(sel, word);
        @(negedge clk);
        if (!hold) tx_valid[sel] = 1'b0;
    endtask

    initial begin
        tx_valid[0] = 1'b0; tx_valid[1] = 1'b0;
        tx_data[0]  = 8'h00; tx_data[1]  = 8'h00;

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle(0, "reset");
            check_idle(1, "reset_p");
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle(0, "post_reset");

        // Single frame, no parity: 40 busy cycles.
        send(0, 8'hA5, 1'b0, "a5");
        drain(0, "a5", 1'b0, -1);
        check_idle(0, "a5_end");

        // Parity frames: 44 cycles, even parity 0 then 1.
        send(1, 8'hA5, 1'b0, "pa5");
        drain(1, "pa5", 1'b0, -1);
        check_idle(1, "pa5_end");
        send(1, 8'h07, 1'b0, "p07");
        drain(1, "p07", 1'b0, -1);
        check_idle(1, "p07_end");

        // Back-to-back with tx_valid held: one idle cycle between frames.
        send(0, 8'h00, 1'b1, "b2b0");
        drain(0, "b2b0", 1'b0, -1);
        check_idle(0, "b2b_gap");
        send(0, 8'hFF, 1'b0, "b2b1");
        drain(0, "b2b1", 1'b0, -1);
        check_idle(0, "b2b1_end");

        // Input disturbance while busy must not alter the frame or re-handshake.
        send(0, 8'h5A, 1'b0, "dist");
        drain(0, "dist", 1'b1, -1);
        check_idle(0, "dist_end");
        @(negedge clk);
        check_idle(0, "dist_quiet");

        // Asynchronous reset during the third data bit.
        send(0, 8'hC3, 1'b0, "abrt");
        drain(0, "abrt", 1'b0, 4 + 2 * CPB + 1);
        check_idle(0, "abrt_hold");
        rst = 1'b0;
        @(negedge clk);
        check_idle(0, "abrt_rel");
        @(negedge clk);
        check_idle(0, "abrt_quiet");
        send(0, 8'h81, 1'b0, "x81");
        drain(0, "x81", 1'b0, -1);
        check_idle(0, "x81_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-to-serial transmitter: accepts one DATA_W-bit word per valid/ready handshake and shifts it out on a single line as a UART-style frame.
- Frame order: start bit (0), data LSB first, optional even-parity bit, stop bit (1).
- Sits between a lab-board word source (switches or a counter) and the serial pin.
- It is the sending end of the team's serial link and the counterpart of the serial receiver block.

Parameters:
- DATA_W, 8: data bits per frame, range 5..9.
- CLKS_PER_BIT, 4: clk cycles per serial bit, minimum 2.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tx_valid  input  1  source has a word on tx_data.
- tx_data  input  DATA_W  word to send, sampled only on handshake.
- tx_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line, idle high.
- busy  output  1  a frame is in progress.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high on rst. All outputs are registered.
- Reset values: tx_out=1, tx_ready=1, busy=0, FSM=IDLE, bit counter=0, timer=0.
- Asserting rst mid-frame aborts the frame immediately; the line returns high and the word is not re-sent.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_ready=1, tx_out=1, busy=0.
  - Handshake occurs on a clk edge where tx_valid=1 and tx_ready=1.
  - On handshake: tx_data is latched into the shift register, tx_ready goes to 0, busy goes to 1, tx_out goes to 0, and the FSM moves to START.
  - Latency: tx_out falls in the cycle after the accepting edge.
- START: lasts CLKS_PER_BIT cycles, then DATA.
- DATA: DATA_W bits, each CLKS_PER_BIT cycles, LSB first. The shift register shifts right once per bit.
- PARITY: entered only if PARITY_EN=1. Lasts CLKS_PER_BIT cycles. tx_out = XOR of all latched data bits (even parity).
- STOP: lasts CLKS_PER_BIT cycles with tx_out=1, then IDLE.
- Frame length:
  - PARITY_EN=0: (DATA_W+2)*CLKS_PER_BIT cycles, start-bit cycle to last stop cycle inclusive.
  - PARITY_EN=1: (DATA_W+3)*CLKS_PER_BIT cycles.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs on wrap. The timer clears on every state entry.
- Bit counter: width clog2(DATA_W+1). It counts data bits; DATA exits after bit DATA_W-1 completes.
- Back-to-back frames: tx_ready rises in the first IDLE cycle. If tx_valid is held high, the next frame is accepted in that cycle, giving exactly one idle-high cycle between the stop bit and the next start bit.
- While busy, tx_valid and tx_data are ignored. Changes on tx_data mid-frame do not alter the frame.
- tx_valid may drop without a handshake; no handshake occurs and no state changes.

Decomposition:
- Shared package holds:
  - FSM state encodings ST_IDLE..ST_STOP, 3 bits.
  - Line level constants LINE_IDLE=1 and START_BIT=0.
  - These are also used by the serial receiver.
- Sub-module bit_timer (parameter CLKS_PER_BIT):
  - Inputs: clk, rst, clr.
  - Output: tick, a one-cycle pulse on the last cycle of each bit.
  - The FSM advances on tick.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release -> tx_out=1, tx_ready=1, busy=0 in all cycles, including while rst is asserted asynchronously mid-cycle.
- Single frame (DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=0): pulse tx_valid with tx_data=8'hA5 -> tx_out shows 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. busy is high for exactly 40 cycles. tx_ready is low for the same 40 cycles.
- Parity (PARITY_EN=1):
  - send 8'hA5 -> parity bit 0, frame 44 cycles.
  - send 8'h07 -> parity bit 1.
- Back-to-back: hold tx_valid=1, send 8'h00 then 8'hFF -> exactly 1 idle-high cycle between the first stop bit and the second start bit. Second frame data bits are all 1.
- Mid-frame disturbance: change tx_data to 8'h3C and toggle tx_valid during the DATA state of an 8'h5A frame -> transmitted bits still match 8'h5A. No second handshake occurs until tx_ready=1.
- Reset mid-frame: assert rst during the 3rd data bit -> tx_out=1 and busy=0 immediately (asynchronously). After release, the block is IDLE and accepts 8'h81 normally.
